rr_arb_mux: RTL and testbench



---
 rtl/rrmux_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/rr_arb_mux.sv | 102 ++++++++++
 tb/tb_rr_arb_mux.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrmux_pkg.sv
// Shared defaults and the grant-index width helper for the round-robin mux.
package rrmux_pkg;

  localparam int DATA_W     = 64;
  localparam int CH_DEFAULT = 8;

  function automatic int sel_w(input int ch);
    return (ch > 2) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping at CH.
module rr_arbiter
  import rrmux_pkg::*;
#(
  parameter  int CH   = CH_DEFAULT,
  localparam int SELW = sel_w(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            any_req
);

  logic [SELW:0] w_idx;

  // One extra index bit so ptr+k never overflows before the explicit wrap.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < CH; k++) begin
      w_idx = {1'b0, ptr} + (SELW+1)'(k);
      if (w_idx >= (SELW+1)'(CH)) w_idx = w_idx - (SELW+1)'(CH);
      if (!any_req && (w_idx < (SELW+1)'(CH)) && req[w_idx[SELW-1:0]]) begin
        any_req = 1'b1;
        grant   = w_idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated CH:1 mux feeding one registered valid/ready output stage.
// Define RRMUX_PACKET_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_arb_mux
  import rrmux_pkg::*;
#(
  parameter  int N    = DATA_W,
  parameter  int CH   = CH_DEFAULT,
  localparam int SELW = sel_w(CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
`ifdef RRMUX_PACKET_LOCK_EN
  input  logic [CH-1:0]   in_last,
`endif
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            r_out_valid;
  logic [N-1:0]    r_out_data;
  logic [SELW-1:0] r_out_sel;
  logic [SELW-1:0] r_ptr;

  logic            w_can_load;
  logic            w_arb_any;
  logic            w_ready_en;
  logic            w_xfer;
  logic [SELW-1:0] w_arb_grant;
  logic [SELW-1:0] w_grant;
  logic [SELW-1:0] w_ptr_next;
  logic [N-1:0]    w_sel_data;

  rr_arbiter #(.CH(CH)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .grant   (w_arb_grant),
    .any_req (w_arb_any)
  );

  assign w_can_load = !r_out_valid || out_ready;

`ifdef RRMUX_PACKET_LOCK_EN
  logic            r_lock;
  logic [SELW-1:0] r_lock_ch;

  // A locked channel is offered ready even while its valid is low.
  assign w_grant    = r_lock ? r_lock_ch : w_arb_grant;
  assign w_ready_en = r_lock || w_arb_any;
`else
  assign w_grant    = w_arb_grant;
  assign w_ready_en = w_arb_any;
`endif

  assign w_xfer     = !reset && w_can_load && w_ready_en && in_valid[w_grant];
  assign w_sel_data = in_data[32'(w_grant)*N +: N];
  assign w_ptr_next = (w_grant == SELW'(CH-1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    in_ready = '0;
    if (!reset && w_can_load && w_ready_en) in_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
`ifdef RRMUX_PACKET_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant;
`ifdef RRMUX_PACKET_LOCK_EN
      if (in_last[w_grant]) begin
        r_lock <= 1'b0;
        r_ptr  <= w_ptr_next;
      end else begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_grant;
      end
`else
      r_ptr       <= w_ptr_next;
`endif
    end else if (w_can_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (CH=8 and CH=5 instances) against a behavioural model.
// Lock scenario is compiled only when RRMUX_PACKET_LOCK_EN is defined.
module tb_rr_arb_mux;

  localparam int N   = 64;
  localparam int CH  = 8;
  localparam int N5  = 16;
  localparam int CH5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [N-1:0]    out_data;
  logic [2:0]      out_sel;
  logic            out_valid;
  logic            out_ready;

  logic [CH5*N5-1:0] d5_in_data;
  logic [CH5-1:0]    d5_in_valid;
  logic [CH5-1:0]    d5_in_ready;
  logic [N5-1:0]     d5_out_data;
  logic [2:0]        d5_out_sel;
  logic              d5_out_valid;
  logic              d5_out_ready;

`ifdef RRMUX_PACKET_LOCK_EN
  logic [CH-1:0]  in_last;
  logic [CH5-1:0] d5_in_last;
`endif

  rr_arb_mux #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef RRMUX_PACKET_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.N(N5), .CH(CH5)) dut5 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (d5_in_data),
    .in_valid  (d5_in_valid),
`ifdef RRMUX_PACKET_LOCK_EN
    .in_last   (d5_in_last),
`endif
    .in_ready  (d5_in_ready),
    .out_data  (d5_out_data),
    .out_sel   (d5_out_sel),
    .out_valid (d5_out_valid),
    .out_ready (d5_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the CH=8 instance.
  bit           m_valid;
  logic [N-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  bit           m_lock;
  int           m_lock_ch;
  int           m_g;
  bit           m_any;

  function automatic void model_arb();
    m_any = 1'b0;
    m_g   = 0;
    if (m_lock) begin
      m_any = 1'b1;
      m_g   = m_lock_ch;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (!m_any && in_valid[(m_ptr + k) % CH]) begin
          m_any = 1'b1;
          m_g   = (m_ptr + k) % CH;
        end
      end
    end
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    logic [CH-1:0] r;
    r = '0;
    model_arb();
    if (!reset && (!m_valid || out_ready) && m_any) r[m_g] = 1'b1;
    return r;
  endfunction

  function automatic void model_edge();
    bit cl;
    model_arb();
    cl = !m_valid || out_ready;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
      m_lock  = 1'b0;
    end else if (cl && m_any && in_valid[m_g]) begin
      m_valid = 1'b1;
      m_data  = in_data[m_g*N +: N];
      m_sel   = m_g;
`ifdef RRMUX_PACKET_LOCK_EN
      if (in_last[m_g]) begin
        m_lock = 1'b0;
        m_ptr  = (m_g + 1) % CH;
      end else begin
        m_lock    = 1'b1;
        m_lock_ch = m_g;
      end
`else
      m_ptr = (m_g + 1) % CH;
`endif
    end else if (cl) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    d5_in_valid = '0;
    d5_out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 8'hFF;
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_ready cyc %0d: got %h expected 00", c, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, out_data, out_sel} !== {1'b0, 64'd0, 3'd0}) begin
        n_fail++;
        $display("FAIL reset_out cyc %0d: got v=%b d=%h s=%0d expected 0/0/0", c, out_valid, out_data, out_sel);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 8'h01) begin
      n_fail++;
      $display("FAIL first_grant_ready: got %h expected 01", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 3'd0, in_data[0 +: N]}) begin
      n_fail++;
      $display("FAIL first_grant_out: got v=%b s=%0d d=%h expected 1/0/%h", out_valid, out_sel, out_data, in_data[0 +: N]);
    end
  endtask

  task automatic test_all_valid();
    reset_dut();
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = 64'(i + 100);
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_checks++;
      if (in_ready !== (8'h01 << (c % 8))) begin
        n_fail++;
        $display("FAIL all_valid_ready cyc %0d: got %h expected %h", c, in_ready, 8'h01 << (c % 8));
      end
      tick();
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'(c % 8), 64'(100 + c % 8)}) begin
        n_fail++;
        $display("FAIL all_valid_out cyc %0d: got v=%b s=%0d d=%0d expected 1/%0d/%0d", c, out_valid, out_sel, out_data, c % 8, 100 + c % 8);
      end
    end
  endtask

  task automatic test_two_channels();
    int exp_seq[5] = '{2, 6, 2, 6, 2};
    reset_dut();
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = {$urandom, $urandom};
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0) ? 8'h04 : 8'h44;
      #1;
      tick();
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'(exp_seq[c]), in_data[exp_seq[c]*N +: N]}) begin
        n_fail++;
        $display("FAIL two_ch_grant step %0d: got v=%b s=%0d expected 1/%0d", c, out_valid, out_sel, exp_seq[c]);
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] held;
    reset_dut();
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = {$urandom, $urandom};
    held = in_data[5*N +: N];
    in_valid = 8'h20;
    out_ready = 1'b1;
    #1;
    tick();
    in_valid = 8'hFF;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < CH; i++) in_data[i*N +: N] = {$urandom, $urandom};
      #1;
      n_checks++;
      if (in_ready !== 8'h00) begin
        n_fail++;
        $display("FAIL stall_ready cyc %0d: got %h expected 00", c, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 3'd5, held}) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: got v=%b s=%0d d=%h expected 1/5/%h", c, out_valid, out_sel, out_data, held);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 8'h40) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %h expected 40", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_sel} !== {1'b1, 3'd6}) begin
      n_fail++;
      $display("FAIL stall_release_sel: got v=%b s=%0d expected 1/6", out_valid, out_sel);
    end
  endtask

  task automatic test_drain();
    in_valid = 8'h00;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_ready: got %h expected 00", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_sel} !== {1'b0, 3'd6}) begin
      n_fail++;
      $display("FAIL drain_out: got v=%b s=%0d expected 0/6", out_valid, out_sel);
    end
    in_valid = 8'hFF;
    #1;
    n_checks++;
    if (in_ready !== 8'h80) begin
      n_fail++;
      $display("FAIL drain_ptr_kept: got %h expected 80", in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [CH-1:0] er;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      in_valid = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) in_data[i*N +: N] = {$urandom, $urandom};
`ifdef RRMUX_PACKET_LOCK_EN
      in_last = 8'($urandom);
`endif
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er) begin
        n_fail++;
        $display("FAIL random_ready cyc %0d: got %h expected %h", c, in_ready, er);
      end
      tick();
      n_checks++;
      if ({out_valid, out_sel, out_data} !== {m_valid, 3'(m_sel), m_data}) begin
        n_fail++;
        $display("FAIL random_out cyc %0d: got v=%b s=%0d d=%h expected %b/%0d/%h", c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
    end
    reset = 1'b0;
`ifdef RRMUX_PACKET_LOCK_EN
    in_last = '1;
`endif
  endtask

  task automatic test_ch5_wrap();
    int exp_seq[6] = '{0, 4, 0, 4, 0, 4};
    reset_dut();
    for (int i = 0; i < CH5; i++) d5_in_data[i*N5 +: N5] = 16'(i + 200);
    d5_in_valid = 5'b10001;
    d5_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      tick();
      n_checks++;
      if ({d5_out_valid, d5_out_sel, d5_out_data} !== {1'b1, 3'(exp_seq[c]), 16'(200 + exp_seq[c])}) begin
        n_fail++;
        $display("FAIL ch5_wrap step %0d: got v=%b s=%0d d=%0d expected 1/%0d/%0d", c, d5_out_valid, d5_out_sel, d5_out_data, exp_seq[c], 200 + exp_seq[c]);
      end
    end
    d5_in_valid = '0;
  endtask

`ifdef RRMUX_PACKET_LOCK_EN
  task automatic test_packet_lock();
    logic [CH-1:0] v_seq[5]  = '{8'h0B, 8'h09, 8'h0B, 8'h0B, 8'h09};
    logic [CH-1:0] l_seq[5]  = '{8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFF};
    logic [CH-1:0] r_seq[5]  = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h08};
    int            s_seq[5]  = '{1, 1, 1, 1, 3};
    bit            ov_seq[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    reset_dut();
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = {$urandom, $urandom};
    out_ready = 1'b1;
    in_valid = 8'h01;
    in_last = 8'hFF;
    #1;
    tick();
    for (int c = 0; c < 5; c++) begin
      in_valid = v_seq[c];
      in_last = l_seq[c];
      #1;
      n_checks++;
      if (in_ready !== r_seq[c]) begin
        n_fail++;
        $display("FAIL lock_ready step %0d: got %h expected %h", c, in_ready, r_seq[c]);
      end
      tick();
      n_checks++;
      if ({out_valid, out_sel} !== {ov_seq[c], 3'(s_seq[c])}) begin
        n_fail++;
        $display("FAIL lock_out step %0d: got v=%b s=%0d expected %b/%0d", c, out_valid, out_sel, ov_seq[c], s_seq[c]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_data = '0;
    in_valid = '0;
    out_ready = 1'b1;
    d5_in_data = '0;
    d5_in_valid = '0;
    d5_out_ready = 1'b1;
`ifdef RRMUX_PACKET_LOCK_EN
    in_last = '1;
    d5_in_last = '1;
`endif
    m_valid = 1'b0;
    m_data = '0;
    m_sel = 0;
    m_ptr = 0;
    m_lock = 1'b0;
    m_lock_ch = 0;
    test_reset();
    test_all_valid();
    test_two_channels();
    test_stall();
    test_drain();
    test_ch5_wrap();
`ifdef RRMUX_PACKET_LOCK_EN
    test_packet_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
